// File: rtl/pacoblaze_alu_seq_pkg.sv
// Shared operation codes, shift selectors and FSM state type for the
// registered PacoBlaze ALU and its combinational datapath.
package pacoblaze_alu_seq_pkg;

  localparam int OPERATION_WIDTH = 4;

  typedef logic [OPERATION_WIDTH-1:0] operation_t;

  localparam operation_t OP_LOAD    = 4'd0;
  localparam operation_t OP_AND     = 4'd1;
  localparam operation_t OP_OR      = 4'd2;
  localparam operation_t OP_XOR     = 4'd3;
  localparam operation_t OP_TEST    = 4'd4;
  localparam operation_t OP_ADD     = 4'd5;
  localparam operation_t OP_ADDCY   = 4'd6;
  localparam operation_t OP_SUB     = 4'd7;
  localparam operation_t OP_SUBCY   = 4'd8;
  localparam operation_t OP_COMPARE = 4'd9;
  localparam operation_t OP_RS      = 4'd10;
  localparam operation_t OP_MUL     = 4'd11;
  localparam operation_t OP_RSN     = 4'd12;

  localparam logic [2:0] OPCODE_RR  = 3'd0;
  localparam logic [2:0] OPCODE_RL  = 3'd1;
  localparam logic [2:0] OPCODE_RSA = 3'd2;
  localparam logic [2:0] OPCODE_RSC = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pacoblaze_alu_comb.sv
// Combinational single-cycle ALU datapath, including the 1-bit shifter that
// the sequencer also reuses for each step of a multi-bit shift.
module pacoblaze_alu_comb
  import pacoblaze_alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  operation_t       operation_i,
  input  logic [2:0]       shift_operation_i,
  input  logic             shift_direction_i,
  input  logic             shift_constant_i,
  input  logic             carry_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o
);

  logic             fill;
  logic [WIDTH:0]   wide;
  logic             carryUsed;

  always_comb begin
    case (shift_operation_i)
      OPCODE_RR:  fill = operand_a_i[0];
      OPCODE_RL:  fill = operand_a_i[WIDTH-1];
      OPCODE_RSA: fill = carry_i;
      default:    fill = shift_constant_i;
    endcase
  end

  // Carry in only participates for the with-carry arithmetic variants.
  assign carryUsed = carry_i && (operation_i == OP_ADDCY || operation_i == OP_SUBCY);

  always_comb begin
    wide     = '0;
    result_o = operand_b_i;
    carry_o  = 1'b0;
    case (operation_i)
      OP_ADD, OP_ADDCY: begin
        wide     = {1'b0, operand_a_i} + {1'b0, operand_b_i} + {{WIDTH{1'b0}}, carryUsed};
        result_o = wide[WIDTH-1:0];
        carry_o  = wide[WIDTH];
      end
      OP_SUB, OP_SUBCY, OP_COMPARE: begin
        wide     = {1'b0, operand_a_i} - {1'b0, operand_b_i} - {{WIDTH{1'b0}}, carryUsed};
        result_o = wide[WIDTH-1:0];
        carry_o  = wide[WIDTH];
      end
      OP_AND: result_o = operand_a_i & operand_b_i;
      OP_OR:  result_o = operand_a_i | operand_b_i;
      OP_XOR: result_o = operand_a_i ^ operand_b_i;
      OP_TEST: begin
        result_o = operand_a_i & operand_b_i;
        carry_o  = ^(operand_a_i & operand_b_i);
      end
      OP_RS: begin
        if (shift_direction_i) begin
          result_o = {fill, operand_a_i[WIDTH-1:1]};
          carry_o  = operand_a_i[0];
        end else begin
          result_o = {operand_a_i[WIDTH-2:0], fill};
          carry_o  = operand_a_i[WIDTH-1];
        end
      end
      default: ;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/pacoblaze_alu_seq.sv
// Registered PacoBlaze ALU with Z/C flag register, valid/ready handshakes and
// two multi-cycle operations: shift-add multiply and multi-bit shift/rotate.
module pacoblaze_alu_seq
  import pacoblaze_alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  operation_t       operation,
  input  logic [2:0]       shift_operation,
  input  logic             shift_direction,
  input  logic             shift_constant,
  input  logic [SHW-1:0]   shift_amount,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero_out,
  output logic             carry_out
);

  state_t           state_q;
  logic             outValid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] resultHi_q;
  logic             zero_q;
  logic             carry_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] shiftVal_q;
  logic             shiftCarry_q;
  logic [2:0]       shOp_q;
  logic             shDir_q;
  logic             shConst_q;
  logic             zeroAmt_q;
  logic [SHW-1:0]   count_q;

  logic             accept;
  logic             inShift;
  operation_t       aluOp;
  logic [2:0]       aluShOp;
  logic             aluShDir;
  logic             aluShConst;
  logic             aluCarryIn;
  logic [WIDTH-1:0] aluA;
  logic [WIDTH-1:0] aluResult;
  logic             aluCarry;
  logic             aluZero;
  logic [WIDTH:0]   mulSum_d;
  logic [WIDTH-1:0] accNext_d;
  logic [WIDTH-1:0] mplierNext_d;

  assign in_ready  = reset_n && (state_q == ST_IDLE) && (!outValid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = outValid_q;
  assign result    = result_q;
  assign result_hi = resultHi_q;
  assign zero_out  = zero_q;
  assign carry_out = carry_q;

  // During a multi-bit shift the datapath is steered to a 1-bit shift of the
  // running value, with the captured shift controls and the running carry.
  assign inShift    = (state_q == ST_SHIFT);
  assign aluOp      = inShift ? OP_RS : operation;
  assign aluShOp    = inShift ? shOp_q : shift_operation;
  assign aluShDir   = inShift ? shDir_q : shift_direction;
  assign aluShConst = inShift ? shConst_q : shift_constant;
  assign aluCarryIn = inShift ? shiftCarry_q : carry_q;
  assign aluA       = inShift ? shiftVal_q : operand_a;

  pacoblaze_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .operation_i       (aluOp),
    .shift_operation_i (aluShOp),
    .shift_direction_i (aluShDir),
    .shift_constant_i  (aluShConst),
    .carry_i           (aluCarryIn),
    .operand_a_i       (aluA),
    .operand_b_i       (operand_b),
    .result_o          (aluResult),
    .carry_o           (aluCarry),
    .zero_o            (aluZero)
  );

  // One shift-add step: the {acc, mplier} pair shifts right as product bits settle.
  assign mulSum_d     = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign accNext_d    = mulSum_d[WIDTH:1];
  assign mplierNext_d = {mulSum_d[0], mplier_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      outValid_q   <= 1'b0;
      result_q     <= '0;
      resultHi_q   <= '0;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
      acc_q        <= '0;
      mplier_q     <= '0;
      mcand_q      <= '0;
      shiftVal_q   <= '0;
      shiftCarry_q <= 1'b0;
      shOp_q       <= '0;
      shDir_q      <= 1'b0;
      shConst_q    <= 1'b0;
      zeroAmt_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (operation == OP_MUL) begin
              state_q    <= ST_MUL;
              outValid_q <= 1'b0;
              acc_q      <= '0;
              mplier_q   <= operand_b;
              mcand_q    <= operand_a;
              count_q    <= SHW'(WIDTH - 1);
            end else if (operation == OP_RSN) begin
              state_q      <= ST_SHIFT;
              outValid_q   <= 1'b0;
              shiftVal_q   <= operand_a;
              shiftCarry_q <= carry_q;
              shOp_q       <= shift_operation;
              shDir_q      <= shift_direction;
              shConst_q    <= shift_constant;
              zeroAmt_q    <= (shift_amount == '0);
              count_q      <= (shift_amount == '0) ? '0 : shift_amount - SHW'(1);
            end else begin
              outValid_q <= 1'b1;
              result_q   <= aluResult;
              resultHi_q <= '0;
              zero_q     <= aluZero;
              carry_q    <= aluCarry;
            end
          end else if (out_ready) begin
            outValid_q <= 1'b0;
          end
        end
        ST_MUL: begin
          acc_q    <= accNext_d;
          mplier_q <= mplierNext_d;
          if (count_q == '0) begin
            state_q    <= ST_DONE;
            outValid_q <= 1'b1;
            result_q   <= mplierNext_d;
            resultHi_q <= accNext_d;
            carry_q    <= |accNext_d;
            zero_q     <= ({accNext_d, mplierNext_d} == '0);
          end else begin
            count_q <= count_q - SHW'(1);
          end
        end
        ST_SHIFT: begin
          // A zero shift count still spends one cycle and keeps the carry flag.
          if (zeroAmt_q) begin
            state_q    <= ST_DONE;
            outValid_q <= 1'b1;
            result_q   <= shiftVal_q;
            resultHi_q <= '0;
            zero_q     <= (shiftVal_q == '0);
          end else begin
            shiftVal_q   <= aluResult;
            shiftCarry_q <= aluCarry;
            if (count_q == '0) begin
              state_q    <= ST_DONE;
              outValid_q <= 1'b1;
              result_q   <= aluResult;
              resultHi_q <= '0;
              zero_q     <= aluZero;
              carry_q    <= aluCarry;
            end else begin
              count_q <= count_q - SHW'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q    <= ST_IDLE;
            outValid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
